button_rr_arbiter: RTL and testbench
====================================

Name: button_rr_arbiter

Overview:
- Round-robin arbiter that shares the single FSM step input between N_REQ debounced button requesters.
- Each press (rising edge) becomes a latched pending request.
- Grants are issued one at a time, aligned to the slow debounce tick, followed by a tick-counted hold-off so the downstream Moore FSM sees exactly one clean step per press.
- Sits between the debounce stage and the FSM in the button top level.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- HOLDOFF, 2, slow ticks spent in HOLD after each grant (0..15).
- ID_W, 1, grant_id width; must be max(1, clog2(N_REQ)).

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-high reset.
- tick_en  in  1  one-clk strobe at slow-tick rate (e.g. 190 Hz divider output).
- req  in  N_REQ  debounced button levels, synchronous to clk.
- grant_valid  out  1  one-clk pulse: a step is granted.
- grant_id  out  ID_W  index of the granted requester; valid with grant_valid, otherwise holds its last value.
- grant_onehot  out  N_REQ  one-hot form of the grant; zero when grant_valid=0.
- pending  out  N_REQ  latched, not-yet-served presses.
- busy  out  1  high when state is not IDLE.
- state  out  2  IDLE=0, GRANT=1, HOLD=2.

Behaviour:
- Reset: state=IDLE, pending=0, rr_ptr=0, hold_cnt=0, grant_valid=0, grant_id=0, grant_onehot=0.
  - req_q resets to all ones, so a button held through reset is not counted until it is released and pressed again.
- Edge detect: each clk, req_q <= req; rise[i] = req[i] & ~req_q[i].
- Pending latch:
  - rise[i] sets pending[i].
  - A grant to i clears pending[i].
  - Set and clear on the same cycle: set wins, so the new press remains pending.
  - A rise while pending[i] is already 1 is merged (one press lost).
- IDLE:
  - Condition: tick_en=1 and pending!=0.
  - Select the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Register grant_id/onehot, clear that pending bit, set rr_ptr = (winner+1) mod N_REQ, go to GRANT.
  - Without tick_en, stay in IDLE.
- GRANT:
  - grant_valid=1 for exactly this one clk.
  - Next state: HOLD with hold_cnt=HOLDOFF, or IDLE if HOLDOFF=0.
- HOLD:
  - On each tick_en, hold_cnt decrements.
  - On the tick_en where hold_cnt==1, go to IDLE.
  - New presses still latch into pending during HOLD.
- Latency:
  - A req rise sampled at cycle k gives pending at k+1.
  - The grant decision is made on the first tick_en in IDLE at or after k+1.
  - grant_valid is asserted the following cycle.
- Spacing: back-to-back grants are at least HOLDOFF+1 ticks apart.
- Fairness: with all requesters continuously pending, grants rotate 0,1,..,N_REQ-1,0.
- tick_en held high continuously is legal; HOLD then lasts HOLDOFF clks.
- clr mid-operation: immediate return to reset values; any in-flight grant_valid is cut off; pending presses are discarded.

Optional Feature:
- Macro: BUTTON_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt[7:0], which counts rises merged into an already-set pending bit.
  - Saturates at 255 and resets to 0 on clr.
  - Two simultaneous merges in one cycle add 2, still saturating.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with req=2'b01 held -> pending stays 0 and no grant_valid until req[0] falls and rises again.
- N_REQ=2, HOLDOFF=2; pulse req[1] high -> pending=2'b10, grant_valid one clk after the next tick_en with grant_id=1 and grant_onehot=2'b10, then HOLD for exactly 2 ticks, then IDLE.
- Both req rise in the same cycle, rr_ptr=0 -> grant_id=0 first, grant_id=1 after hold-off, rr_ptr ends at 0; gap between grants is 3 ticks.
- A press on req[0] during HOLD -> latched; granted on the first tick after returning to IDLE.
- Assert clr in the GRANT cycle -> grant_valid drops immediately; state=0, pending=0, busy=0.
- With BUTTON_ARB_DROP_CNT_EN: three presses on req[0] before its grant -> drop_cnt=2; 300 merged presses -> drop_cnt=255.

Source files
------------

// File: rtl/button_rr_arbiter.sv
// Round-robin arbiter turning debounced button presses into single, tick-aligned FSM steps.
// Optional BUTTON_ARB_DROP_CNT_EN adds a saturating count of presses merged into a pending bit.
module button_rr_arbiter #(
  parameter int N_REQ   = 2,
  parameter int HOLDOFF = 2,
  parameter int ID_W    = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             tick_en,
  input  logic [N_REQ-1:0] req,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [N_REQ-1:0] pending,
  output logic             busy,
  output logic [1:0]       state
`ifdef BUTTON_ARB_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] sel_onehot;
  logic [N_REQ-1:0] clear_mask;
  logic [N_REQ-1:0] probe_mask;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  next_ptr;
  logic [3:0]       hold_cnt, hold_cnt_d;
  logic             sel_found;
  logic             take;
  int               idx;

  assign rise = req & ~req_q;

  // Rotating priority search: first pending bit at or after rr_ptr, wrapping.
  always_comb begin
    sel_found  = 1'b0;
    sel_id     = '0;
    sel_onehot = '0;
    idx        = 0;
    probe_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      probe_mask = N_REQ'(1) << idx;
      if (!sel_found && (|(pending & probe_mask))) begin
        sel_found  = 1'b1;
        sel_id     = ID_W'(idx);
        sel_onehot = probe_mask;
      end
    end
  end

  assign take       = (state_q == IDLE) && tick_en && sel_found;
  assign clear_mask = take ? sel_onehot : '0;
  assign next_ptr   = (int'(sel_id) == N_REQ - 1) ? '0 : sel_id + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt;
    case (state_q)
      IDLE: begin
        if (take) state_d = GRANT;
      end
      GRANT: begin
        if (HOLDOFF == 0) begin
          state_d = IDLE;
        end else begin
          state_d    = HOLD;
          hold_cnt_d = 4'(HOLDOFF);
        end
      end
      HOLD: begin
        if (tick_en) begin
          hold_cnt_d = hold_cnt - 4'd1;
          if (hold_cnt <= 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
      req_q    <= '1;
      pending  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_cnt_d;
      req_q    <= req;
      pending  <= (pending & ~clear_mask) | rise;
      if (take) begin
        rr_ptr   <= next_ptr;
        grant_id <= sel_id;
      end
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_onehot = grant_valid ? (N_REQ'(1) << grant_id) : '0;
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

`ifdef BUTTON_ARB_DROP_CNT_EN
  logic [N_REQ-1:0] merges;
  logic [3:0]       merge_cnt;
  logic [8:0]       drop_sum;

  // A press landing on a bit that stays pending is lost; the grant-clear cycle is not a loss.
  assign merges = rise & pending & ~clear_mask;

  always_comb begin
    merge_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      merge_cnt = merge_cnt + 4'(merges[i]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 9'(merge_cnt);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_button_rr_arbiter.sv
// Self-checking bench for button_rr_arbiter: behavioural model checked every cycle,
// plus directed literal checks for reset, hold-off, fairness and mid-grant clear.
module tb_button_rr_arbiter;

  localparam int N  = 2;
  localparam int HO = 2;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         tick_en = 1'b0;
  logic [N-1:0] req = 2'b01;
  logic         grant_valid;
  logic [0:0]   grant_id;
  logic [N-1:0] grant_onehot;
  logic [N-1:0] pending;
  logic         busy;
  logic [1:0]   state;
`ifdef BUTTON_ARB_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  button_rr_arbiter #(.N_REQ(N), .HOLDOFF(HO), .ID_W(1)) dut (
    .clk          (clk),
    .clr          (clr),
    .tick_en      (tick_en),
    .req          (req),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .pending      (pending),
    .busy         (busy),
    .state        (state)
`ifdef BUTTON_ARB_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a grant is an event, followed by a number of remaining hold-off ticks.
  bit [N-1:0] m_prev_req, m_pending, m_rise, m_clear;
  int         m_ptr, m_gid, m_hold, m_drop, m_win;
  bit         m_gv, m_new_gv;

  always @(posedge clk) begin
    if (clr) begin
      m_prev_req = '1;
      m_pending  = '0;
      m_ptr      = 0;
      m_gid      = 0;
      m_hold     = 0;
      m_gv       = 1'b0;
      m_drop     = 0;
    end else begin
      m_rise     = req & ~m_prev_req;
      m_prev_req = req;
      m_clear    = '0;
      m_new_gv   = 1'b0;
      if (m_gv) begin
        m_hold = HO;
      end else if (m_hold > 0) begin
        if (tick_en) m_hold = m_hold - 1;
      end else if (tick_en && m_pending != 0) begin
        m_win = -1;
        for (int k = 0; k < N; k++) begin
          if (m_win < 0 && m_pending[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        end
        m_new_gv = 1'b1;
        m_gid    = m_win;
        m_ptr    = (m_win + 1) % N;
        m_clear[m_win] = 1'b1;
      end
      m_drop    = m_drop + $countones(m_rise & m_pending & ~m_clear);
      if (m_drop > 255) m_drop = 255;
      m_pending = (m_pending & ~m_clear) | m_rise;
      m_gv      = m_new_gv;
    end
    #1;
    checkOutput("m_grant_valid", 32'(grant_valid), 32'(m_gv));
    checkOutput("m_grant_id", 32'(grant_id), 32'(m_gid));
    checkOutput("m_grant_onehot", 32'(grant_onehot), m_gv ? 32'(1 << m_gid) : 32'd0);
    checkOutput("m_pending", 32'(pending), 32'(m_pending));
    checkOutput("m_busy", 32'(busy), 32'(m_gv || m_hold > 0));
    checkOutput("m_state", 32'(state), m_gv ? 32'd1 : (m_hold > 0 ? 32'd2 : 32'd0));
`ifdef BUTTON_ARB_DROP_CNT_EN
    checkOutput("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  end

  task automatic applyStimulus(input logic t, input logic [N-1:0] r);
    @(negedge clk);
    tick_en = t;
    req     = r;
    @(posedge clk);
    #2;
  endtask

  task automatic slowTick(input logic [N-1:0] r);
    applyStimulus(1'b0, r);
    applyStimulus(1'b0, r);
    applyStimulus(1'b1, r);
  endtask

  int rnd_mode;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    // req[0] held through reset must not become a request
    repeat (4) applyStimulus(1'b1, 2'b01);
    checkOutput("held_no_pending", 32'(pending), 32'd0);
    checkOutput("held_no_grant", 32'(busy), 32'd0);
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b01);
    checkOutput("repress_pending", 32'(pending), 32'h1);
    applyStimulus(1'b1, 2'b01);
    checkOutput("repress_gv", 32'(grant_valid), 32'd1);
    checkOutput("repress_onehot", 32'(grant_onehot), 32'h1);
    slowTick(2'b01);
    slowTick(2'b01);
    checkOutput("repress_idle", 32'(state), 32'd0);

    // single press on req[1], exactly HO ticks of hold
    applyStimulus(1'b0, 2'b10);
    checkOutput("p1_pending", 32'(pending), 32'h2);
    applyStimulus(1'b1, 2'b00);
    checkOutput("p1_gv", 32'(grant_valid), 32'd1);
    checkOutput("p1_gid", 32'(grant_id), 32'd1);
    checkOutput("p1_onehot", 32'(grant_onehot), 32'h2);
    applyStimulus(1'b0, 2'b00);
    checkOutput("p1_hold", 32'(state), 32'd2);
    slowTick(2'b00);
    checkOutput("p1_hold_after1", 32'(state), 32'd2);
    slowTick(2'b00);
    checkOutput("p1_idle_after2", 32'(state), 32'd0);

    // simultaneous presses: 0 first, then 1 after hold-off
    applyStimulus(1'b0, 2'b11);
    checkOutput("both_pending", 32'(pending), 32'h3);
    applyStimulus(1'b1, 2'b11);
    checkOutput("both_first_gid", 32'(grant_id), 32'd0);
    slowTick(2'b11);
    slowTick(2'b11);
    checkOutput("both_gap_idle", 32'(grant_valid), 32'd0);
    slowTick(2'b11);
    checkOutput("both_second_gv", 32'(grant_valid), 32'd1);
    checkOutput("both_second_gid", 32'(grant_id), 32'd1);
    checkOutput("both_drained", 32'(pending), 32'd0);

    // press during HOLD is latched and served on first idle tick
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b01);
    checkOutput("hold_press_latched", 32'(pending), 32'h1);
    checkOutput("hold_press_state", 32'(state), 32'd2);
    slowTick(2'b01);
    slowTick(2'b01);
    checkOutput("hold_press_idle", 32'(state), 32'd0);
    slowTick(2'b01);
    checkOutput("hold_press_gv", 32'(grant_valid), 32'd1);
    checkOutput("hold_press_gid", 32'(grant_id), 32'd0);
    slowTick(2'b00);
    slowTick(2'b00);

    // clr asserted during GRANT cuts everything off at once
    applyStimulus(1'b0, 2'b10);
    applyStimulus(1'b0, 2'b11);
    applyStimulus(1'b1, 2'b11);
    checkOutput("clr_pre_gid", 32'(grant_id), 32'd1);
    checkOutput("clr_pre_pending", 32'(pending), 32'h1);
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("clr_gv", 32'(grant_valid), 32'd0);
    checkOutput("clr_state", 32'(state), 32'd0);
    checkOutput("clr_pending", 32'(pending), 32'd0);
    checkOutput("clr_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;

    // randomized traffic with slow and continuous tick phases
    rnd_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 250 == 0) rnd_mode = $urandom_range(0, 1);
      tick_en = rnd_mode == 1 ? 1'b1 : ($urandom_range(0, 5) == 0);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 6) == 0) req[b] = ~req[b];
      end
      clr = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    clr = 1'b0;

`ifdef BUTTON_ARB_DROP_CNT_EN
    @(negedge clk);
    clr = 1'b1;
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 2'b01);
      applyStimulus(1'b0, 2'b00);
    end
    checkOutput("drop_three", 32'(drop_cnt), 32'd2);
    for (int p = 0; p < 300; p++) begin
      applyStimulus(1'b0, 2'b01);
      applyStimulus(1'b0, 2'b00);
    end
    checkOutput("drop_saturate", 32'(drop_cnt), 32'd255);
`endif

    repeat (2) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
